// File: rtl/uart_fifo_bridge.sv
// CPU-side FIFO bridge to the simple_uart register port: TX/RX FIFOs plus a polling FSM.
// Optional interrupt logic is enabled by defining UART_FIFO_BRIDGE_IRQ_EN.
module uart_fifo_bridge #(
    parameter int unsigned TX_AW      = 4,
    parameter int unsigned RX_AW      = 4,
    parameter logic [31:0] BAUD_RESET = 32'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [1:0]  mem_addr_i,
    input  logic [3:0]  mem_wstrb_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        uart_sel_o,
    output logic [1:0]  uart_addr_o,
    output logic        uart_we_o,
    output logic [31:0] uart_wdat_o,
    input  logic [31:0] uart_rdat_i,
    output logic        irq_o
);
    localparam int unsigned TxDepth = 1 << TX_AW;
    localparam int unsigned RxDepth = 1 << RX_AW;

    typedef enum logic [2:0] {
        StIdle, StWrBsr, StRdSr, StWtSr, StRdIdr, StWtIdr, StClr, StWrOdr
    } state_e;

    state_e state_q, state_d;

    logic [7:0]     tx_mem_q [TxDepth];
    logic [7:0]     rx_mem_q [RxDepth];
    logic [TX_AW:0] tx_wp_q, tx_rp_q;
    logic [RX_AW:0] rx_wp_q, rx_rp_q;
    logic           served_q, ready_q, baud_pend_q, uart_busy_q, sr_fe_q;
    logic           txovf_q, rxovf_q, fe_q;
    logic [31:0]    rdata_q, rdata_d, baud_q, ctrl_rd;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic accept, cpu_wr, cpu_rd, ctrl_wr;
    logic tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
    logic [7:0] stat;
    logic unused_rdat;

    assign unused_rdat = ^uart_rdat_i[31:8];

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                      (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) &&
                      (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);

    // One ack per request: re-arm only after mem_valid_i has dropped.
    assign accept  = mem_valid_i & ~served_q;
    assign cpu_wr  = accept & (|mem_wstrb_i);
    assign cpu_rd  = accept & ~(|mem_wstrb_i);
    assign ctrl_wr = cpu_wr && (mem_addr_i == 2'd3);

    assign tx_pop      = (state_q == StWrOdr);
    assign tx_push_req = cpu_wr && (mem_addr_i == 2'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_pop      = cpu_rd && (mem_addr_i == 2'd0) && !rx_empty;
    assign rx_push_req = (state_q == StWtIdr);
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    assign stat = {fe_q, rxovf_q, txovf_q, rx_full, ~rx_empty, tx_full, tx_empty, uart_busy_q};

    always_comb begin
        rdata_d = '0;
        if (cpu_rd) begin
            case (mem_addr_i)
                2'd0:    rdata_d = rx_empty ? 32'd0
                                            : {23'd0, 1'b1, rx_mem_q[rx_rp_q[RX_AW-1:0]]};
                2'd1:    rdata_d = {24'd0, stat};
                2'd2:    rdata_d = baud_q;
                default: rdata_d = ctrl_rd;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        uart_sel_o  = 1'b0;
        uart_addr_o = 2'd0;
        uart_we_o   = 1'b0;
        uart_wdat_o = '0;
        unique case (state_q)
            StIdle:  state_d = baud_pend_q ? StWrBsr : StRdSr;
            StWrBsr: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = 2'd2;
                uart_we_o   = 1'b1;
                uart_wdat_o = baud_q;
                state_d     = StIdle;
            end
            StRdSr: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = 2'd3;
                state_d     = StWtSr;
            end
            StWtSr: begin
                if (uart_rdat_i[1])                     state_d = StRdIdr;
                else if (!tx_empty && !uart_rdat_i[0])  state_d = StWrOdr;
                else                                    state_d = StIdle;
            end
            StRdIdr: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = 2'd1;
                state_d     = StWtIdr;
            end
            StWtIdr: state_d = StClr;
            StClr: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = 2'd3;
                uart_we_o   = 1'b1;
                state_d     = StIdle;
            end
            StWrOdr: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = 2'd0;
                uart_we_o   = 1'b1;
                uart_wdat_o = {24'd0, tx_mem_q[tx_rp_q[TX_AW-1:0]]};
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= mem_wdata_i[7:0];
        if (rx_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= uart_rdat_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            served_q    <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            baud_q      <= BAUD_RESET;
            baud_pend_q <= 1'b0;
            uart_busy_q <= 1'b0;
            sr_fe_q     <= 1'b0;
            txovf_q     <= 1'b0;
            rxovf_q     <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= accept | (served_q & mem_valid_i);
            ready_q  <= accept;
            rdata_q  <= rdata_d;
            if (tx_push) tx_wp_q <= tx_wp_q + {{TX_AW{1'b0}}, 1'b1};
            if (tx_pop)  tx_rp_q <= tx_rp_q + {{TX_AW{1'b0}}, 1'b1};
            if (rx_push) rx_wp_q <= rx_wp_q + {{RX_AW{1'b0}}, 1'b1};
            if (rx_pop)  rx_rp_q <= rx_rp_q + {{RX_AW{1'b0}}, 1'b1};
            // A CPU write in the WR_BSR cycle wins so the newest value is sent later.
            if (cpu_wr && (mem_addr_i == 2'd2)) begin
                baud_q      <= mem_wdata_i;
                baud_pend_q <= 1'b1;
            end else if (state_q == StWrBsr) begin
                baud_pend_q <= 1'b0;
            end
            if (state_q == StWtSr) begin
                uart_busy_q <= uart_rdat_i[0];
                sr_fe_q     <= uart_rdat_i[2];
            end
            txovf_q <= (txovf_q & ~(ctrl_wr & mem_wdata_i[0])) | (tx_push_req & ~tx_push);
            rxovf_q <= (rxovf_q & ~(ctrl_wr & mem_wdata_i[1])) | (rx_push_req & ~rx_push);
            fe_q    <= (fe_q & ~(ctrl_wr & mem_wdata_i[2])) | (rx_push_req & sr_fe_q);
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;

`ifdef UART_FIFO_BRIDGE_IRQ_EN
    logic [1:0] ie_q;
    logic       irq_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ie_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= mem_wdata_i[5:4];
            irq_q <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty);
        end
    end

    assign irq_o   = irq_q;
    assign ctrl_rd = {26'd0, ie_q, 4'd0};
`else
    assign irq_o   = 1'b0;
    assign ctrl_rd = '0;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: UART register model, queue-based reference model,
// directed scenarios plus randomized TX/RX rounds.
module tb_uart_fifo_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready;
    logic [1:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_rdata;
    logic        usel, uwe, irq;
    logic [1:0]  uaddr;
    logic [31:0] uwdat, urdat;

    int tests = 0;
    int fails = 0;

    uart_fifo_bridge dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_ready_o (mem_ready),
        .mem_addr_i  (mem_addr),
        .mem_wstrb_i (mem_wstrb),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .uart_sel_o  (usel),
        .uart_addr_o (uaddr),
        .uart_we_o   (uwe),
        .uart_wdat_o (uwdat),
        .uart_rdat_i (urdat),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  tx_model[$];
    logic [7:0]  rx_model[$];
    logic        txovf_m = 0, rxovf_m = 0, fe_m = 0;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        int          a;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- UART model ----------------
    logic [7:0]  u_idr = 0;
    logic [2:0]  u_sr = 0;
    logic [31:0] u_bsr = 0;
    logic [8:0]  inj_q[$];
    logic [7:0]  sent_q[$];
    bit          force_busy = 0;
    int busy_cnt = 0, busy_len = 3, gap_cnt = 0;
    int odr_err = 0, clr_err = 0, bad_wr = 0, idr_cnt = 0, clr_cnt = 0, bsr_cnt = 0;
    int last_acc = 0, sr_since = 0, sr_before_bsr = 0;
    bit baud_watch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            u_sr = 0; busy_cnt = 0; urdat = 0; inj_q.delete();
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (usel === 1'b1) begin
                if (uwe) begin
                    case (uaddr)
                        2'd0: begin
                            if (busy_cnt > 0 || force_busy) odr_err++;
                            sent_q.push_back(uwdat[7:0]);
                            busy_cnt = busy_len;
                        end
                        2'd2: begin
                            bsr_cnt++; u_bsr = uwdat;
                            if (baud_watch) begin sr_before_bsr = sr_since; baud_watch = 0; end
                        end
                        2'd3: begin
                            if (last_acc != 1) clr_err++;
                            u_sr[2:1] = 2'b00; clr_cnt++;
                        end
                        default: bad_wr++;
                    endcase
                end else begin
                    case (uaddr)
                        2'd0: urdat = 0;
                        2'd1: begin urdat = {24'd0, u_idr}; idr_cnt++; end
                        2'd2: urdat = u_bsr;
                        default: begin
                            urdat = {29'd0, u_sr[2:1], (busy_cnt > 0) || force_busy};
                            if (baud_watch) sr_since++;
                        end
                    endcase
                end
                last_acc = uwe ? 10 + int'(uaddr) : int'(uaddr);
            end
            if (!u_sr[1] && inj_q.size() > 0) begin
                if (gap_cnt > 0) gap_cnt--;
                else begin
                    logic [8:0] v;
                    v = inj_q.pop_front();
                    u_idr = v[7:0]; u_sr[2] = v[8]; u_sr[1] = 1'b1;
                    gap_cnt = $urandom_range(0, 6);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (mem_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_ack: mem_ready_o=1 with no request outstanding");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) begin
                        tests++;
                        if (mem_rdata !== e.val) begin
                            fails++;
                            $display("FAIL rdata(addr %0d): got 0x%0h, expected 0x%0h",
                                     e.a, mem_rdata, e.val);
                        end
                    end
                end
            end
`ifndef UART_FIFO_BRIDGE_IRQ_EN
            tests++;
            if (irq !== 1'b0) begin fails++; $display("FAIL irq_tied: got %b, expected 0", irq); end
`endif
        end
    end

    // ---------------- CPU bus and model tasks ----------------
    task automatic cpu(input logic [1:0] a, input bit wr, input logic [31:0] wd,
                       input bit chk_rd, input logic [31:0] expv);
        exp_t e;
        int n;
        e.chk = !wr && chk_rd; e.val = expv; e.a = int'(a);
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_valid = 1; mem_addr = a; mem_wstrb = wr ? 4'hF : 4'h0; mem_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_ready !== 1'b1 && n < 8);
        chk("ack_latency", n, 2);
        if (mem_ready !== 1'b1) void'(exp_q.pop_back());
        if (wr && a == 2'd2) begin baud_watch = 1; sr_since = 0; end
        @(posedge clk); #1;
        mem_valid = 0; mem_wstrb = 0;
    endtask

    function automatic logic [31:0] stat_exp(input bit busy);
        int occ = tx_model.size() - sent_q.size();
        return {24'd0, fe_m, rxovf_m, txovf_m, rx_model.size() == 16, rx_model.size() != 0,
                occ == 16, occ == 0, busy};
    endfunction

    task automatic wr_data(input logic [7:0] b);
        if (tx_model.size() - sent_q.size() >= 16) txovf_m = 1;
        else tx_model.push_back(b);
        cpu(2'd0, 1, {24'd0, b}, 0, 0);
    endtask

    task automatic rd_data();
        logic [31:0] e;
        e = 0;
        if (rx_model.size() > 0) e = {23'd0, 1'b1, rx_model.pop_front()};
        cpu(2'd0, 0, 0, 1, e);
    endtask

    task automatic inject(input logic fe, input logic [7:0] b);
        inj_q.push_back({fe, b});
        if (fe) fe_m = 1;
        if (rx_model.size() >= 16) rxovf_m = 1;
        else rx_model.push_back(b);
    endtask

    int tx_checked = 0;
    task automatic wait_quiet();
        int n = 0;
        while ((inj_q.size() > 0 || u_sr[1] || busy_cnt > 0 ||
                sent_q.size() < tx_model.size()) && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("quiet_timeout", n < 3000, 1);
        repeat (12) @(negedge clk);
        for (int i = tx_checked; i < tx_model.size(); i++)
            chk("tx_byte", (i < sent_q.size()) ? sent_q[i] : 8'hxx, tx_model[i]);
        tx_checked = tx_model.size();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int i0, c0, b0, n;
        mem_valid = 0; mem_addr = 0; mem_wstrb = 0; mem_wdata = 0;
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_uart", {usel, uwe, uaddr}, 0);
        chk("rst_wdat", uwdat, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);

        // reset register values
        cpu(2'd1, 0, 0, 1, 32'h02);
        cpu(2'd0, 0, 0, 1, 32'h0);
        cpu(2'd2, 0, 0, 1, 32'h2);
        cpu(2'd3, 0, 0, 1, 32'h0);

        // two TX bytes in order
        busy_len = 4;
        wr_data(8'h55); wr_data(8'hA3);
        wait_quiet();
        chk("tx_two_count", sent_q.size(), 2);
        cpu(2'd1, 0, 0, 1, 32'h02);

        // single RX byte
        i0 = idr_cnt; c0 = clr_cnt;
        inject(0, 8'h3C);
        wait_quiet();
        chk("idr_reads", idr_cnt - i0, 1);
        chk("clr_writes", clr_cnt - c0, 1);
        cpu(2'd0, 0, 0, 1, 32'h13C);
        cpu(2'd0, 0, 0, 1, 32'h0);
        rx_model.delete();

        // RX overflow: 17 bytes, no CPU reads
        for (int i = 0; i < 17; i++) inject(0, 8'($urandom));
        wait_quiet();
        cpu(2'd1, 0, 0, 1, 32'h5A);
        for (int i = 0; i < 16; i++) rd_data();
        cpu(2'd3, 1, 32'h2, 0, 0); rxovf_m = 0;
        cpu(2'd1, 0, 0, 1, 32'h02);

        // BAUD update while TX pending behind a busy UART
        force_busy = 1;
        repeat (12) @(negedge clk);
        b0 = bsr_cnt; sr_before_bsr = 99;
        wr_data(8'h11); wr_data(8'h22); wr_data(8'h33);
        cpu(2'd2, 1, 32'h1B1, 0, 0);
        repeat (20) @(negedge clk);
        chk("bsr_count", bsr_cnt - b0, 1);
        chk("bsr_value", u_bsr, 32'h1B1);
        chk("bsr_before_sr", sr_before_bsr <= 1, 1);
        force_busy = 0;
        wait_quiet();
        chk("bsr_count_final", bsr_cnt - b0, 1);
        cpu(2'd2, 0, 0, 1, 32'h1B1);

        // TX overflow against a stalled UART
        force_busy = 1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 17; i++) wr_data(8'($urandom));
        cpu(2'd1, 0, 0, 1, stat_exp(1));
        cpu(2'd1, 0, 0, 1, 32'h25);
        cpu(2'd3, 1, 32'h1, 0, 0); txovf_m = 0;
        cpu(2'd1, 0, 0, 1, 32'h05);
        force_busy = 0;
        wait_quiet();
        cpu(2'd1, 0, 0, 1, 32'h02);

        // framing error flag
        inject(1, 8'h99);
        wait_quiet();
        cpu(2'd1, 0, 0, 1, 32'h8A);
        rd_data();
        cpu(2'd3, 1, 32'h4, 0, 0); fe_m = 0;
        cpu(2'd1, 0, 0, 1, 32'h02);

`ifdef UART_FIFO_BRIDGE_IRQ_EN
        cpu(2'd3, 1, 32'h10, 0, 0);
        cpu(2'd3, 0, 0, 1, 32'h10);
        chk("irq_idle", irq, 0);
        inject(0, 8'h7E);
        wait_quiet();
        chk("irq_rx", irq, 1);
        rd_data();
        chk("irq_rx_clear", irq, 0);
        cpu(2'd3, 1, 32'h20, 0, 0);
        repeat (3) @(negedge clk);
        chk("irq_txe", irq, 1);
        cpu(2'd3, 1, 32'h0, 0, 0);
        repeat (3) @(negedge clk);
        chk("irq_off", irq, 0);
`else
        cpu(2'd3, 1, 32'h30, 0, 0);
        cpu(2'd3, 0, 0, 1, 32'h0);
        inject(0, 8'h7E);
        wait_quiet();
        rd_data();
`endif

        // randomized rounds: TX only, RX only, or both at once
        for (int r = 0; r < 12; r++) begin
            int kind, m, nt;
            kind = $urandom_range(0, 2);
            busy_len = $urandom_range(0, 10);
            m = (kind != 0) ? $urandom_range(1, 16) : 0;
            nt = (kind != 1) ? $urandom_range(1, 16) : 0;
            for (int i = 0; i < m; i++) inject(0, 8'($urandom));
            for (int i = 0; i < nt; i++) begin
                wr_data(8'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            wait_quiet();
            cpu(2'd1, 0, 0, 1, stat_exp(0));
            for (int i = 0; i <= m; i++) rd_data();
        end

        // reset in the middle of a transfer drops FIFO contents
        force_busy = 1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) wr_data(8'($urandom));
        n = sent_q.size();
        @(posedge clk); #1 rst = 0; force_busy = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        tx_model.delete(); rx_model.delete(); sent_q.delete();
        tx_checked = 0; txovf_m = 0; rxovf_m = 0; fe_m = 0;
        n = 0;
        cpu(2'd1, 0, 0, 1, 32'h02);
        cpu(2'd2, 0, 0, 1, 32'h2);
        repeat (30) @(negedge clk);
        chk("no_tx_after_reset", sent_q.size(), n);

        repeat (4) @(negedge clk);
        chk("odr_while_busy", odr_err, 0);
        chk("clr_order", clr_err, 0);
        chk("bad_uart_write", bad_wr, 0);
        chk("pending_acks", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
